// File: rtl/window_gen33_pkg.sv
// Shared LeNet definitions: pixel type, per-layer image sizes and kernel size.
// Used by the window generator and by the convolution stages it feeds.
package window_gen33_pkg;

  localparam int PIX_W = 8;
  typedef logic signed [PIX_W-1:0] pix_t;

  localparam int IMG_DIM_C1 = 28;
  localparam int IMG_DIM_S2 = 14;
  localparam int IMG_DIM_C3 = 10;
  localparam int IMG_DIM_S4 = 5;

  localparam int K = 3;

  function automatic int winPerFrame(input int w, input int h);
    return (w - K + 1) * (h - K + 1);
  endfunction

endpackage

// File: rtl/window_gen33_if.sv
// Pixel stream in, 3x3 window plus strobes out. The producer side uses the
// master modport and the window generator uses the slave modport.
interface window_gen33_if import window_gen33_pkg::*; #(
  parameter int BIT_WIDTH = PIX_W
);

  logic signed [BIT_WIDTH-1:0] pix_in;
  logic                        pix_valid;
  logic signed [BIT_WIDTH-1:0] in1, in2, in3, in4, in5, in6, in7, in8, in9;
  logic                        en;
  logic                        frame_done;

  modport master (
    output pix_in, pix_valid,
    input  in1, in2, in3, in4, in5, in6, in7, in8, in9, en, frame_done
  );

  modport slave (
    input  pix_in, pix_valid,
    output in1, in2, in3, in4, in5, in6, in7, in8, in9, en, frame_done
  );

endinterface

// File: rtl/window_gen33_line_buffer.sv
// Fixed-depth shift register holding one image row; the output is the pixel
// that entered DEPTH shifts ago.
module line_buffer import window_gen33_pkg::*; #(
  parameter int DEPTH     = IMG_DIM_C1,
  parameter int BIT_WIDTH = PIX_W
) (
  input  logic                        i_clk,
  input  logic                        i_shift,
  input  logic signed [BIT_WIDTH-1:0] i_din,
  output logic signed [BIT_WIDTH-1:0] o_dout
);

  logic signed [BIT_WIDTH-1:0] r_mem [DEPTH];

  // Contents need no reset: stale rows are masked by the window valid logic.
  always_ff @(posedge i_clk) begin
    if (i_shift) begin
      r_mem[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/window_gen33.sv
// Streaming 3x3 window generator for the LeNet convolution MAC: two row
// buffers plus a 3x3 shift window, strobing en for every interior position.
module window_gen33 import window_gen33_pkg::*; #(
  parameter int BIT_WIDTH = PIX_W,
  parameter int IMG_W     = IMG_DIM_C1,
  parameter int IMG_H     = IMG_DIM_C1
) (
  input logic          clk,
  input logic          rst,
  window_gen33_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  logic [CW-1:0]               r_col;
  logic [RW-1:0]               r_row;
  logic signed [BIT_WIDTH-1:0] r_top [K];
  logic signed [BIT_WIDTH-1:0] r_mid [K];
  logic signed [BIT_WIDTH-1:0] r_bot [K];
  logic                        r_en;
  logic                        r_frameDone;

  logic                        w_accept;
  logic signed [BIT_WIDTH-1:0] w_lb0;
  logic signed [BIT_WIDTH-1:0] w_lb1;

  // Reset wins over a pixel in the same cycle, so the pixel never reaches the buffers.
  assign w_accept = bus.pix_valid & ~rst;

  line_buffer #(.DEPTH(IMG_W), .BIT_WIDTH(BIT_WIDTH)) u_lb0 (
    .i_clk   (clk),
    .i_shift (w_accept),
    .i_din   (bus.pix_in),
    .o_dout  (w_lb0)
  );

  line_buffer #(.DEPTH(IMG_W), .BIT_WIDTH(BIT_WIDTH)) u_lb1 (
    .i_clk   (clk),
    .i_shift (w_accept),
    .i_din   (w_lb0),
    .o_dout  (w_lb1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (bus.pix_valid) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Windows that straddle a row edge or use the first two rows are masked, not flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        r_top[i] <= '0;
        r_mid[i] <= '0;
        r_bot[i] <= '0;
      end
      r_en        <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_en        <= bus.pix_valid && (r_row >= RW'(2)) && (r_col >= CW'(2));
      r_frameDone <= bus.pix_valid && (r_row == LAST_ROW) && (r_col == LAST_COL);
      if (bus.pix_valid) begin
        for (int i = 0; i < K - 1; i++) begin
          r_top[i] <= r_top[i+1];
          r_mid[i] <= r_mid[i+1];
          r_bot[i] <= r_bot[i+1];
        end
        r_top[K-1] <= w_lb1;
        r_mid[K-1] <= w_lb0;
        r_bot[K-1] <= bus.pix_in;
      end
    end
  end

  assign bus.in1        = r_top[0];
  assign bus.in2        = r_top[1];
  assign bus.in3        = r_top[2];
  assign bus.in4        = r_mid[0];
  assign bus.in5        = r_mid[1];
  assign bus.in6        = r_mid[2];
  assign bus.in7        = r_bot[0];
  assign bus.in8        = r_bot[1];
  assign bus.in9        = r_bot[2];
  assign bus.en         = r_en;
  assign bus.frame_done = r_frameDone;

endmodule

// File: tb/tb_window_gen33.sv
// Scoreboard bench for window_gen33: the driver queues each expected window
// with the cycle it must appear in; a monitor pops and compares on every en.
module tb_window_gen33;
  import window_gen33_pkg::*;

  localparam int W = 28;
  localparam int H = 28;

  typedef struct packed {
    logic [71:0] win;
    logic        last;
    int          tag;
    int          r;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycleCnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   winCount = 0;
  int   fdCount = 0;

  exp_t        expQ[$];
  int          frameWinQ[$];
  logic [71:0] firstWin;
  logic [71:0] row3Win;
  logic [71:0] lastWin;

  window_gen33_if #(.BIT_WIDTH(PIX_W)) bus ();

  window_gen33 #(.BIT_WIDTH(PIX_W), .IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  wire [71:0] actWin = {bus.in1, bus.in2, bus.in3, bus.in4, bus.in5,
                        bus.in6, bus.in7, bus.in8, bus.in9};

  function automatic logic [7:0] pixVal(input int mode, input int r, input int c);
    case (mode)
      1:       return 8'h80;
      2:       return 8'((r * W + c + 1) % 128);
      default: return 8'((r * W + c) % 128);
    endcase
  endfunction

  function automatic logic [71:0] windowAt(input int mode, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      w[71 - 8*k -: 8] = pixVal(mode, r - 2 + k / 3, c - 2 + k % 3);
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [73:0] act, input logic [73:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Streams one frame (optionally aborting at stopRow/stopCol) with random idle gaps.
  task automatic applyStimulus(input int mode, input int gapPct, input int stopRow, input int stopCol);
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stopRow && c == stopCol) return;
        while (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
          @(negedge clk);
          bus.pix_valid = 1'b0;
          bus.pix_in    = 8'h7F;
        end
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_in    = pixVal(mode, r, c);
        if (r >= 2 && c >= 2) begin
          e.win  = windowAt(mode, r, c);
          e.last = (r == H - 1) && (c == W - 1);
          e.tag  = cycleCnt + 1;
          e.r    = r;
          e.c    = c;
          expQ.push_back(e);
        end
      end
    end
  endtask

  task automatic drain();
    @(negedge clk);
    bus.pix_valid = 1'b0;
    #1;
    for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d windows outstanding, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic checkFrame(input string name);
    checks++;
    if (frameWinQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: no completed frame recorded, expected %0d windows", name, winPerFrame(W, H));
    end else begin
      int n;
      n = frameWinQ.pop_front();
      if (n != winPerFrame(W, H)) begin
        errors++;
        $display("[TB] FAIL %s: got %0d windows expected %0d", name, n, winPerFrame(W, H));
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.en) begin
      checks++;
      if (expQ.size() == 0 || expQ[0].tag != cycleCnt) begin
        errors++;
        $display("[TB] FAIL en_timing: en=1 at cycle %0d, next expected window cycle %0d",
                 cycleCnt, (expQ.size() == 0) ? -1 : expQ[0].tag);
      end else begin
        e = expQ.pop_front();
        checks++;
        if (actWin !== e.win) begin
          errors++;
          $display("[TB] FAIL window(%0d,%0d): got %h expected %h", e.r, e.c, actWin, e.win);
        end
        checks++;
        if (bus.frame_done !== e.last) begin
          errors++;
          $display("[TB] FAIL frame_done(%0d,%0d): got %b expected %b", e.r, e.c, bus.frame_done, e.last);
        end
        if (e.r == 2 && e.c == 2) firstWin = actWin;
        if (e.r == 3 && e.c == 2) row3Win = actWin;
        winCount++;
        if (e.last) begin
          lastWin = actWin;
          frameWinQ.push_back(winCount);
          winCount = 0;
        end
      end
    end else begin
      if (expQ.size() > 0 && expQ[0].tag == cycleCnt) begin
        checks++;
        errors++;
        $display("[TB] FAIL missing_en: en=0 at cycle %0d, expected 1 for window (%0d,%0d)",
                 cycleCnt, expQ[0].r, expQ[0].c);
        void'(expQ.pop_front());
      end
      if (bus.frame_done) begin
        checks++;
        errors++;
        $display("[TB] FAIL frame_done_alone: frame_done=1 with en=0 at cycle %0d, expected en=1", cycleCnt);
      end
    end
    if (bus.frame_done) fdCount++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", {2'b00, actWin, bus.en, bus.frame_done}, '0);
    rst = 1'b0;

    $display("[TB] ramp frame, gap-free");
    fdCount = 0;
    applyStimulus(0, 0, -1, -1);
    drain();
    checkFrame("ramp_count");
    checkOutput("ramp_first_win", {2'b00, firstWin},
                {2'b00, 8'd0, 8'd1, 8'd2, 8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58});
    checkOutput("row3_first_win", {50'd0, row3Win[71:64], row3Win[55:48], row3Win[7:0]},
                {50'd0, 8'd28, 8'd30, 8'd86});
    checkOutput("ramp_last_in9", {66'd0, lastWin[7:0]}, {66'd0, 8'd15});
    checkOutput("ramp_frame_done_count", 74'(fdCount), 74'd1);

    $display("[TB] ramp frame with idle gaps");
    applyStimulus(0, 40, -1, -1);
    drain();
    checkFrame("gap_count");
    checkOutput("gap_first_win", {2'b00, firstWin},
                {2'b00, 8'd0, 8'd1, 8'd2, 8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58});

    $display("[TB] negative data frame");
    applyStimulus(1, 0, -1, -1);
    drain();
    checkFrame("neg_count");
    checkOutput("neg_last_win", {2'b00, lastWin}, {2'b00, {9{8'h80}}});

    $display("[TB] back-to-back frames");
    applyStimulus(0, 0, -1, -1);
    applyStimulus(2, 0, -1, -1);
    drain();
    checkFrame("b2b_count_0");
    checkFrame("b2b_count_1");
    checkOutput("b2b_second_first_win", {2'b00, firstWin},
                {2'b00, 8'd1, 8'd2, 8'd3, 8'd29, 8'd30, 8'd31, 8'd57, 8'd58, 8'd59});

    $display("[TB] reset mid-frame then fresh frame");
    applyStimulus(0, 0, 10, 5);
    drain();
    winCount = 0;
    @(negedge clk);
    rst           = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_in    = 8'h55;
    @(negedge clk);
    checkOutput("after_reset", {2'b00, actWin, bus.en, bus.frame_done}, '0);
    rst           = 1'b0;
    bus.pix_valid = 1'b0;
    applyStimulus(0, 0, -1, -1);
    drain();
    checkFrame("fresh_count");
    checkOutput("fresh_first_win", {2'b00, firstWin},
                {2'b00, 8'd0, 8'd1, 8'd2, 8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58});
    checkOutput("fresh_last_in9", {66'd0, lastWin[7:0]}, {66'd0, 8'd15});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
